// File: rtl/sram_mem_controller.sv
// MEM-stage controller that splits 32-bit loads/stores into two 16-bit accesses
// on an asynchronous SRAM, followed by a fixed number of wait states.
module sram_mem_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

   state_t        state_r, state_next_s;
   logic [1:0]    cmd_r;              // [1] = write, [0] = read
   logic [16:0]   word_r;
   logic [31:0]   data_r;
   logic [CW-1:0] cnt_r, cnt_next_s;
   logic [15:0]   rd_lo_r, rd_hi_r;
   logic [31:0]   read_data_r;
   logic [17:0]   sram_addr_r, addr_next_s;
   logic [15:0]   dq_out_r, dq_out_next_s;
   logic          dq_oe_r, dq_oe_next_s;
   logic          we_n_r, we_n_next_s;
   logic [31:0]   offset_s;
   logic          req_s;
   logic          unused_offset_s;

   assign req_s           = wr_en | rd_en;
   assign offset_s        = address - 32'(BASE_ADDR);
   // Byte-lane bits and bits beyond the SRAM range are deliberately discarded.
   assign unused_offset_s = ^{offset_s[31:19], offset_s[1:0]};

   assign ready       = ~(req_s & (state_r != S_DONE));
   assign read_data   = read_data_r;
   assign sram_addr   = sram_addr_r;
   assign sram_dq_out = dq_out_r;
   assign sram_dq_oe  = dq_oe_r;
   assign sram_we_n   = we_n_r;

   // Next-state and next SRAM pin values; pins are registered so they align with the new state.
   always_comb begin
      state_next_s   = state_r;
      cnt_next_s     = cnt_r;
      addr_next_s    = sram_addr_r;
      dq_out_next_s  = 16'h0000;
      dq_oe_next_s   = 1'b0;
      we_n_next_s    = 1'b1;
      case (state_r)
         S_IDLE: begin
            if (req_s) begin
               state_next_s = S_LO;
               addr_next_s  = {offset_s[18:2], 1'b0};
               if (wr_en) begin
                  dq_out_next_s = write_data[15:0];
                  dq_oe_next_s  = 1'b1;
                  we_n_next_s   = 1'b0;
               end else begin
                  dq_out_next_s = 16'h0000;
                  dq_oe_next_s  = 1'b0;
                  we_n_next_s   = 1'b1;
               end
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_LO: begin
            state_next_s = S_HI;
            addr_next_s  = {word_r, 1'b1};
            if (cmd_r[1]) begin
               dq_out_next_s = data_r[31:16];
               dq_oe_next_s  = 1'b1;
               we_n_next_s   = 1'b0;
            end else begin
               dq_out_next_s = 16'h0000;
               dq_oe_next_s  = 1'b0;
               we_n_next_s   = 1'b1;
            end
         end
         S_HI: begin
            state_next_s = S_WAIT;
            cnt_next_s   = CNT_LOAD;
         end
         S_WAIT: begin
            if (cnt_r == '0) begin
               state_next_s = S_DONE;
            end else begin
               cnt_next_s = cnt_r - CW'(1);
            end
         end
         S_DONE: begin
            state_next_s = S_IDLE;
         end
         default: begin
            state_next_s = S_IDLE;
            cnt_next_s   = '0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Command/address latch, wait counter, read capture and registered SRAM pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_r       <= 2'b00;
         word_r      <= 17'd0;
         data_r      <= 32'd0;
         cnt_r       <= '0;
         rd_lo_r     <= 16'h0000;
         rd_hi_r     <= 16'h0000;
         read_data_r <= 32'd0;
         sram_addr_r <= 18'd0;
         dq_out_r    <= 16'h0000;
         dq_oe_r     <= 1'b0;
         we_n_r      <= 1'b1;
      end else begin
         cnt_r       <= cnt_next_s;
         sram_addr_r <= addr_next_s;
         dq_out_r    <= dq_out_next_s;
         dq_oe_r     <= dq_oe_next_s;
         we_n_r      <= we_n_next_s;
         if ((state_r == S_IDLE) && req_s) begin
            cmd_r  <= {wr_en, rd_en & ~wr_en};
            word_r <= offset_s[18:2];
            data_r <= write_data;
         end
         if ((state_r == S_LO) && cmd_r[0]) begin
            rd_lo_r <= sram_dq_in;
         end
         if ((state_r == S_HI) && cmd_r[0]) begin
            rd_hi_r <= sram_dq_in;
         end
         if ((state_r == S_WAIT) && (state_next_s == S_DONE) && cmd_r[0]) begin
            read_data_r <= {rd_hi_r, rd_lo_r};
         end
      end
   end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences MEM-stage data accesses from the EXE/MEM pipeline register onto an external 16-bit asynchronous SRAM.
- Inputs are the ALU result (used as the byte address), the store value and the read/write enables.
- Splits each 32-bit access into two 16-bit half-word cycles, then inserts a fixed number of wait states.
- Drops `ready` for the full access so the hazard/freeze logic can stall IF through MEM.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0; subtracted from `address`.
- WAIT_CYCLES, 2: wait-state cycles after the high half-word access (≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr_en  input  1  store request, MEM_W_EN from the pipeline.
- rd_en  input  1  load request, MEM_R_EN from the pipeline.
- address  input  32  byte address, ALU_result from the pipeline.
- write_data  input  32  store data, Val_Rm from the pipeline.
- read_data  output  32  load result, registered.
- ready  output  1  0 = freeze pipeline; combinational.
- sram_addr  output  18  SRAM half-word address.
- sram_dq_out  output  16  data driven to SRAM.
- sram_dq_oe  output  1  1 = controller drives the DQ bus.
- sram_dq_in  input  16  data returned from SRAM; valid in the same cycle the address is driven.
- sram_we_n  output  1  SRAM write strobe, active-low.

Behaviour:
- States: IDLE, LO, HI, WAIT, DONE. A 2-bit command register (write/read) and a 32-bit address/data latch.
- Offset = address − BASE_ADDR (32-bit wrap). Word index = offset[18:2]; offset bits [1:0] are ignored. Bits above 18 are dropped, with no range check.
- Arbitration: wr_en && rd_en are treated as a write; write wins.
- IDLE:
  - With (wr_en | rd_en): latch command, offset and write_data, then go to LO.
  - Otherwise stay in IDLE.
- LO:
  - sram_addr = {word index, 1'b0}.
  - Write: sram_dq_out = data[15:0], sram_dq_oe = 1, sram_we_n = 0.
  - Read: capture sram_dq_in into rd_lo at the edge.
  - Next state: HI.
- HI:
  - sram_addr = {word index, 1'b1}, using data[31:16] for writes. Read captures into rd_hi.
  - Load the counter with WAIT_CYCLES−1.
  - Next state: WAIT.
- WAIT:
  - Decrement the counter each cycle; go to DONE when it reaches 0.
  - Outputs: sram_we_n = 1, sram_dq_oe = 0.
  - sram_addr holds the last value.
- DONE:
  - Read: read_data <= {rd_hi, rd_lo} at the edge entering DONE, so it is valid throughout DONE.
  - Next state: always IDLE.
- Outside LO/HI writes, sram_we_n = 1 and sram_dq_oe = 0. sram_dq_out = 0 when not driven.
- ready = ~((wr_en | rd_en) & (state != DONE)).
  - In IDLE with no request, ready = 1.
  - In IDLE with a request, ready = 0 in that same cycle.
- Timing: request first seen at cycle 0 gives ready = 0 for cycles 0 … 2+WAIT_CYCLES and ready = 1 at cycle 3+WAIT_CYCLES (cycle 5 with the default).
- The command is latched, so changes on the inputs between LO and DONE are ignored and the access completes.
  - If the request drops mid-access, ready reads 1 but the FSM still runs to DONE, then IDLE.
- Back-to-back: DONE → IDLE, and a request present in IDLE starts immediately. There is no extra idle-ready cycle when the next request is already asserted.
- read_data holds its value until the next read completes. Writes do not alter it.
- rst, at any state including mid-access, applies at the next edge:
  - state = IDLE, counter = 0, read_data = 0, rd_lo = rd_hi = 0.
  - sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0.
  - An interrupted write may leave SRAM partially written; this is not recovered.

Test Plan:
1. Store: wr_en = 1, address = 0x400, write_data = 0xDEADBEEF held until ready → cycle 1: sram_addr = 0, dq_out = 0xBEEF, we_n = 0; cycle 2: sram_addr = 1, dq_out = 0xDEAD, we_n = 0; ready = 0 for cycles 0–4 and 1 at cycle 5.
2. Load: SRAM model preloaded with word 1 = {0x1234, 0x5678}; rd_en = 1, address = 0x404 → sram_addr = 2 then 3, read_data = 0x12345678 at cycle 5 with ready = 1.
3. Arbitration and latch: wr_en = rd_en = 1 at 0x408 → write cycles on addresses 4 and 5. Deassert both at cycle 2 → LO, HI, WAIT, DONE still run, with ready = 1 after the deassert.
4. Back-to-back: store 0x400 then load 0x400 with requests held continuously → second access starts in the IDLE cycle after DONE; read_data equals the stored value; two ready = 1 pulses exactly 6 cycles apart.
5. Reset mid-access: rst = 1 during HI of a write → next cycle state = IDLE, we_n = 1, oe = 0, read_data = 0; ready = 1 with no request.
6. WAIT_CYCLES = 4 instance: a load shows ready = 0 for 7 cycles and ready = 1 on cycle 7.
